// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin owner of a shared inout bus with turnaround.
// Define IO_BUS_ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles.
module io_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  bus_oe,
  inout  wire  [WIDTH-1:0]      vio,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    TURN  = 2'b10
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [IW-1:0]   last;
  logic [IW-1:0]   last_d;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   idx;
  logic            found;
  logic            rel;
  logic [NREQ-1:0] gnt_d;
  logic            oe_d;
  logic [WIDTH-1:0] wslice;

  // Rotating search: first request above the last winner, wrapping.
  always_comb begin
    sel   = last;
    idx   = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

`ifdef IO_BUS_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold;
  logic          others;

  // gnt is the owner's one-hot in GRANT, so this masks the owner out.
  assign others = |(req & ~gnt);
  assign rel    = !req[last] ||
                  ((hold == HW'(MAX_HOLD - 1)) && others);

  // Hold counter: zero outside GRANT, counts grant cycles, saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (state != GRANT) begin
      hold <= '0;
    end else if (hold != HW'(MAX_HOLD - 1)) begin
      hold <= hold + 1'b1;
    end
  end
`else
  logic unused_hold;

  assign unused_hold = |MAX_HOLD;
  assign rel         = !req[last];
`endif

  // Next state: arbitrate in IDLE, hold until release, one turnaround.
  always_comb begin
    state_d = IDLE;
    case (state)
      IDLE:    state_d = found ? GRANT : IDLE;
      GRANT:   state_d = rel ? TURN : GRANT;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Values the registered outputs take on the next edge.
  always_comb begin
    gnt_d  = '0;
    oe_d   = 1'b0;
    last_d = last;
    if (state == IDLE && found) begin
      gnt_d  = NREQ'(1) << sel;
      oe_d   = 1'b1;
      last_d = sel;
    end else if (state == GRANT && !rel) begin
      gnt_d  = gnt;
      oe_d   = 1'b1;
    end
  end

  // State and grant registers; reset drops the bus at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= '0;
      bus_oe <= 1'b0;
      last   <= IW'(NREQ - 1);
    end else begin
      state  <= state_d;
      gnt    <= gnt_d;
      bus_oe <= oe_d;
      last   <= last_d;
    end
  end

  // Sample the bus whenever this block is not driving it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (!bus_oe) begin
      rd_data <= vio;
    end
  end

  assign wslice = wdata[int'(last)*WIDTH +: WIDTH];
  assign vio    = bus_oe ? wslice : {WIDTH{1'bz}};
  assign busy   = (state == GRANT) || (state == TURN);

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed and random stimulus against a
// queue-based reference model, checked by a separate monitor.
module tb_io_bus_arbiter;

  localparam int NREQ     = 4;
  localparam int W        = 4;
  localparam int MAX_HOLD = 8;
`ifdef IO_BUS_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] wdata;
  logic [NREQ-1:0]   gnt;
  logic              bus_oe;
  logic              busy;
  logic [W-1:0]      rd_data;
  logic [W-1:0]      tb_val;
  wire  [W-1:0]      vio;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign vio = bus_oe ? {W{1'bz}} : tb_val;

  io_bus_arbiter #(
    .NREQ(NREQ),
    .WIDTH(W),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .wdata(wdata),
    .gnt(gnt),
    .bus_oe(bus_oe),
    .vio(vio),
    .rd_data(rd_data),
    .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic            oe;
    logic            busy;
    logic [W-1:0]    rd;
    int              owner;
  } exp_t;

  exp_t expq[$];

  // Reference model: who owns the bus, how long, and the sampled value.
  int          m_phase  = 0;
  int          m_owner  = 0;
  int          m_last   = NREQ - 1;
  int          m_served = 0;
  logic [W-1:0] m_rd    = '0;

  always @(posedge clk) begin
    exp_t e;
    bit   hit;
    if (!rst_n) begin
      m_phase = 0;
      m_last  = NREQ - 1;
      m_rd    = '0;
      expq.delete();
    end else begin
      if (m_phase != 1) m_rd = tb_val;
      if (m_phase == 0) begin
        if (req != 0) begin
          hit = 1'b0;
          for (int k = 1; k <= NREQ; k++) begin
            if (!hit && req[(m_last + k) % NREQ]) begin
              m_owner = (m_last + k) % NREQ;
              hit     = 1'b1;
            end
          end
          m_last   = m_owner;
          m_served = 0;
          m_phase  = 1;
        end
      end else if (m_phase == 1) begin
        m_served++;
        if (!req[m_owner]) begin
          m_phase = 2;
        end else if (TMO && m_served >= MAX_HOLD &&
                     (req & ~(NREQ'(1) << m_owner)) != 0) begin
          m_phase = 2;
        end
      end else begin
        m_phase = 0;
      end
      e.gnt   = (m_phase == 1) ? (NREQ'(1) << m_owner) : '0;
      e.oe    = (m_phase == 1);
      e.busy  = (m_phase != 0);
      e.rd    = m_rd;
      e.owner = m_owner;
      expq.push_back(e);
    end
  end

  // Monitor: compare DUT outputs with the oldest expected entry.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      check("sb_gnt", gnt, e.gnt);
      check("sb_oe", bus_oe, e.oe);
      check("sb_busy", busy, e.busy);
      check("sb_rd", rd_data, e.rd);
      if (e.oe) check("sb_vio", vio, wdata[e.owner*W +: W]);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got[$];
    logic [NREQ-1:0] prevg;
    int cnt, zeros, run, gap, stage;
    logic [NREQ-1:0] nxt;

    rst_n  = 1'b0;
    req    = '1;
    wdata  = 16'h3210;
    tb_val = 4'h5;
    repeat (3) @(posedge clk);
    #2;
    check("rst_gnt", gnt, 0);
    check("rst_oe", bus_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_rd", rd_data, 0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("first_gnt", gnt, 4'b0001);
    check("rd_idle", rd_data, 4'h5);

    // Round robin with each owner holding for two cycles.
    prevg = '0;
    cnt   = 0;
    zeros = 0;
    for (int c = 0; c < 80 && got.size() < 5; c++) begin
      @(negedge clk);
      if (gnt == 0) begin
        zeros++;
        prevg = '0;
        req   = '1;
      end else begin
        if (gnt != prevg) begin
          if (got.size() != 0) check("rr_gap", zeros, 2);
          got.push_back($clog2(gnt));
          cnt   = 1;
          zeros = 0;
          prevg = gnt;
        end else begin
          cnt++;
        end
        req = (cnt >= 2) ? ~gnt : '1;
      end
    end
    check("rr_count", got.size(), 5);
    foreach (got[i]) check("rr_order", got[i], i % 4);

    // Late request during another owner's grant: no preemption.
    req = '0;
    repeat (4) @(negedge clk);
    req = 4'b1000;
    repeat (2) @(negedge clk);
    req = 4'b1010;
    repeat (3) @(negedge clk);
    check("late_hold", gnt, 4'b1000);
    req = 4'b0010;
    @(negedge clk);
    check("late_turn", gnt, 0);
    check("late_turn_busy", busy, 1);
    @(negedge clk);
    check("late_idle", gnt, 0);
    check("late_idle_busy", busy, 0);
    @(negedge clk);
    check("late_gnt1", gnt, 4'b0010);

    // Asynchronous reset in the middle of a grant.
    req = '0;
    repeat (4) @(negedge clk);
    wdata = 16'h0A00;
    req   = 4'b0100;
    @(negedge clk);
    check("drv_gnt2", gnt, 4'b0100);
    check("drv_vio", vio, 4'hA);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", gnt, 0);
    check("arst_oe", bus_oe, 0);
    check("arst_busy", busy, 0);
    repeat (2) @(negedge clk);
    req   = '1;
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_first", gnt, 4'b0001);

    // Long hold by requester 0 while requester 1 waits.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    req   = 4'b0011;
    rst_n = 1'b1;
    run   = 0;
    gap   = 0;
    stage = 0;
    nxt   = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stage == 0) begin
        if (gnt == 4'b0001) run++;
        else if (run != 0) stage = 1;
      end
      if (stage == 1) begin
        if (gnt == 0) gap++;
        else begin
          nxt   = gnt;
          stage = 2;
        end
      end
    end
    check("hold_run", run, TMO ? MAX_HOLD : 40);
    check("hold_gap", gap, TMO ? 2 : 0);
    check("hold_next", nxt, TMO ? 4'b0010 : 4'b0000);

    // Random traffic; each request bit flips with probability 1/8.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(7) == 0) req[i] = ~req[i];
      wdata  = NREQ*W'($urandom);
      tb_val = W'($urandom);
    end

    req = '0;
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
